// File: rtl/mem_access_unit_if.sv
// Bundle of the request/response and block-memory signals for mem_access_unit.
//
// Request channel: a request transfers on the clock edge where req_valid and
// req_ready are both high. While req_valid is high the requester holds the
// request fields stable. req_ready is high only when the unit is idle.
// Response channel: resp_valid is a one-cycle pulse with no back-pressure.
// resp_err and resp_rdata are meaningful only while resp_valid is high.
//
// Modports:
//   master - core + block memory side (drives requests and mem_read_data)
//   slave  - mem_access_unit side (drives ready, responses and the memory port)
interface mem_access_unit_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_address, mem_write_enable, mem_write_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_address, mem_write_enable, mem_write_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide block memory with registered
// (1-cycle latency) read data. Accepts byte-addressed byte/half/word
// requests, one in flight. Loads are lane-selected and sign/zero-extended;
// sub-word stores are done as read-modify-write.
//
// Ports:
//   clk       - clock, all state changes on posedge
//   rstn      - synchronous active-low reset
//   bus       - mem_access_unit_if.slave: request, response and memory port
//   dbg_state - current FSM state (0 IDLE, 1 RD, 2 DATA, 3 WR, 4 ERR)
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    mem_access_unit_if.slave      bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_unsigned;
    logic [1:0]        lat_lane;
    logic [15:0]       lat_wdata;
    logic [31:0]       wr_word;
    logic [ADDR_W-1:0] mem_address_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic              req_bad;
    logic [31:0]       shifted;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    // Bits of the request address above the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    // Misaligned half/word or the reserved size code.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Load lane select/extension and sub-word store merge, both operating on
    // the word returned by the memory in DATA.
    always_comb begin
        shifted   = bus.mem_read_data >> {lat_lane, 3'b000};
        load_val  = shifted;
        merge_val = bus.mem_read_data;
        case (lat_size)
            2'b00: begin
                load_val = {{24{~lat_unsigned & shifted[7]}}, shifted[7:0]};
                merge_val[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
            end
            2'b01: begin
                load_val = {{16{~lat_unsigned & shifted[15]}}, shifted[15:0]};
                merge_val[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            lat_we        <= 1'b0;
            lat_size      <= 2'b00;
            lat_unsigned  <= 1'b0;
            lat_lane      <= 2'b00;
            lat_wdata     <= 16'h0;
            wr_word       <= 32'h0;
            mem_address_q <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we       <= bus.req_we;
                        lat_size     <= bus.req_size;
                        lat_unsigned <= bus.req_unsigned;
                        lat_lane     <= bus.req_addr[1:0];
                        lat_wdata    <= bus.req_wdata[15:0];
                        if (req_bad) begin
                            state <= ERR;
                        end else begin
                            // Address only moves for real accesses; it holds in IDLE.
                            mem_address_q <= bus.req_addr[ADDR_W+1:2];
                            wr_word       <= bus.req_wdata;
                            state         <= (bus.req_we && bus.req_size == 2'b10) ? WR : RD;
                        end
                    end
                end
                RD:   state <= DATA;
                DATA: begin
                    if (lat_we) begin
                        wr_word <= merge_val;
                        state   <= WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_val;
                        state        <= IDLE;
                    end
                end
                WR: begin
                    resp_valid_q <= 1'b1;
                    state        <= IDLE;
                end
                ERR: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = (state == IDLE);
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_err         = resp_err_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.mem_address      = mem_address_q;
    // Gated by rstn so a reset landing on WR never commits the write.
    assign bus.mem_write_enable = (state == WR) && rstn;
    assign bus.mem_write_data   = wr_word;
    assign dbg_state            = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural
// registered-read block memory.
module tb_mem_access_unit;
    localparam int ADDR_W = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] dbg_state;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- block memory model ----------------
    logic [31:0] mem [0:31];
    int          we_count = 0;

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            mem[bus.mem_address] <= bus.mem_write_data;
            we_count             <= we_count + 1;
        end
        bus.mem_read_data <= mem[bus.mem_address];
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request and waits for its response. lat = number of edges
    // after the accept edge until resp_valid is seen (-1 on timeout).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata);
        int waited;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat   = -1;
        err   = 1'b0;
        rdata = 32'h0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) begin
                lat   = i;
                err   = bus.resp_err;
                rdata = bus.resp_rdata;
                break;
            end
        end
    endtask

    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          snap;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        // ---------------- reset ----------------
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {29'h0, dbg_state}, 32'd0);
        check("rst_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- 1: word store then word load ----------------
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, lat, err, rdata);
        check("sw_lat", lat, 32'd1);
        check("sw_err", {31'h0, err}, 32'd0);
        check("sw_rdata", rdata, 32'h0);
        check("sw_mem", mem[2], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, err, rdata);
        check("lw_lat", lat, 32'd2);
        check("lw_err", {31'h0, err}, 32'd0);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        // ---------------- 2: byte store and byte loads ----------------
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, err, rdata);
        do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000007F, lat, err, rdata);
        check("sb_lat", lat, 32'd3);
        check("sb_mem", mem[2], 32'h11227F44);
        do_req(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0, lat, err, rdata);
        check("lb_b3", rdata, 32'h00000011);
        do_req(1'b1, 2'b00, 1'b0, 32'h08, 32'hFFFFFF80, lat, err, rdata);
        check("sb0_mem", mem[2], 32'h11227F80);
        do_req(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, lat, err, rdata);
        check("lbu_80", rdata, 32'h00000080);
        do_req(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, lat, err, rdata);
        check("lb_80", rdata, 32'hFFFFFF80);
        check("lb_80_lat", lat, 32'd2);

        // ---------------- 3: half store and half loads ----------------
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, err, rdata);
        do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000ABCD, lat, err, rdata);
        check("sh_lat", lat, 32'd3);
        check("sh_err", {31'h0, err}, 32'd0);
        check("sh_mem", mem[2], 32'hABCD3344);
        do_req(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, lat, err, rdata);
        check("lh_hi", rdata, 32'hFFFFABCD);
        do_req(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, lat, err, rdata);
        check("lhu_hi", rdata, 32'h0000ABCD);
        do_req(1'b0, 2'b01, 1'b0, 32'h08, 32'h0, lat, err, rdata);
        check("lh_lo", rdata, 32'h00003344);

        // ---------------- 4: errors ----------------
        snap = we_count;
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, err, rdata);
        check("lw_mis_lat", lat, 32'd1);
        check("lw_mis_err", {31'h0, err}, 32'd1);
        check("lw_mis_rdata", rdata, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, lat, err, rdata);
        check("lh_mis_err", {31'h0, err}, 32'd1);
        check("lh_mis_lat", lat, 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, lat, err, rdata);
        check("size11_err", {31'h0, err}, 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 32'h0A, 32'h12345678, lat, err, rdata);
        check("sw_mis_err", {31'h0, err}, 32'd1);
        check("sw_mis_rdata", rdata, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h09, 32'h00005555, lat, err, rdata);
        check("sh_mis_err", {31'h0, err}, 32'd1);
        check("err_no_write", we_count, snap);
        check("err_mem_kept", mem[2], 32'hABCD3344);

        // ---------------- 5: reset during WR of a sub-word store ----------------
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, lat, err, rdata);
        snap = we_count;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h08;
        bus.req_wdata    = 32'h00005555;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("rst_wr_state_rd", {29'h0, dbg_state}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_wr_state_wr", {29'h0, dbg_state}, 32'd3);
        check("rst_wr_we_before", {31'h0, bus.mem_write_enable}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_wr_we_gated", {31'h0, bus.mem_write_enable}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_wr_no_resp", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_wr_ready", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_wr_no_resp2", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_wr_no_write", we_count, snap);
        check("rst_wr_mem", mem[2], 32'h11223344);

        // ---------------- 6: back-to-back loads, address aliasing ----------------
        do_req(1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFEF00D, lat, err, rdata);
        do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h01234567, lat, err, rdata);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h80;
        @(posedge clk);                 // accept edge k
        #1 bus.req_addr = 32'h04;       // next request, valid held high
        check("b2b_first_rd", {29'h0, dbg_state}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("b2b_resp1", {31'h0, bus.resp_valid}, 32'd1);
        check("b2b_alias_rdata", bus.resp_rdata, 32'hCAFEF00D);
        check("b2b_ready_in_resp", {31'h0, bus.req_ready}, 32'd1);
        @(posedge clk);                 // second request accepted here
        #1 bus.req_valid = 1'b0;
        check("b2b_second_rd", {29'h0, dbg_state}, 32'd1);
        check("b2b_pulse_1cyc", {31'h0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("b2b_resp2", {31'h0, bus.resp_valid}, 32'd1);
        check("b2b_rdata2", bus.resp_rdata, 32'h01234567);
        check("b2b_err2", {31'h0, bus.resp_err}, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no end of test expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
